// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - IF stage with IF/ID pipeline register; optional static prediction under IF_STATIC_PREDICT_EN
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       PC_out,
    output logic [31:0]       instruction_out,
    output logic              valid_out,
    output logic              pred_taken_out
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] pc_q;
    logic [31:0] fetch_word;
    logic [31:0] seq_pc;
    logic [31:0] pred_target;
    logic        pred;
    logic [31:0] next_pc;

    // Loader write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // Combinational fetch: byte offset ignored, upper PC bits wrap the index.
    assign fetch_word = imem[pc_q[ADDR_W+1:2]];
    assign seq_pc     = pc_q + 32'd4;

`ifdef IF_STATIC_PREDICT_EN
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        is_back_branch;
    logic        is_jal;

    assign imm_b = {{19{fetch_word[31]}}, fetch_word[31], fetch_word[7],
                    fetch_word[30:25], fetch_word[11:8], 1'b0};
    assign imm_j = {{11{fetch_word[31]}}, fetch_word[31], fetch_word[19:12],
                    fetch_word[20], fetch_word[30:21], 1'b0};

    assign is_back_branch = (fetch_word[6:0] == 7'b1100011) && fetch_word[31];
    assign is_jal         = (fetch_word[6:0] == 7'b1101111);

    // Backward branches and jal are predicted taken; everything else falls through.
    always_comb begin
        pred        = 1'b0;
        pred_target = seq_pc;
        if (is_back_branch) begin
            pred        = 1'b1;
            pred_target = pc_q + imm_b;
        end else if (is_jal) begin
            pred        = 1'b1;
            pred_target = pc_q + imm_j;
        end
    end
`else
    assign pred        = 1'b0;
    assign pred_target = seq_pc;
`endif

    // Next-PC selection: EX redirect beats stall, stall beats prediction.
    always_comb begin
        next_pc = seq_pc;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc_q;
        end else if (pred) begin
            next_pc = pred_target;
        end
    end

    // Program counter; a redirect pending on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    // IF/ID register: flush inserts a bubble even while stalled.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            PC_out          <= 32'h0000_0000;
            instruction_out <= NOP;
            valid_out       <= 1'b0;
            pred_taken_out  <= 1'b0;
        end else if (!stall) begin
            PC_out          <= pc_q;
            instruction_out <= fetch_word;
            valid_out       <= 1'b1;
            pred_taken_out  <= pred;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized and directed bench for instr_fetch_stage against a behavioural model
module tb_instr_fetch_stage;

    localparam int          DEPTH    = 256;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] W_A      = 32'h0010_0093;
    localparam logic [31:0] W_B      = 32'h0020_0113;
    localparam logic [31:0] W_C      = 32'h0030_0193;
    localparam logic [31:0] W_D      = 32'h0040_0213;
    localparam logic [31:0] W_E      = 32'h0050_0293;
    localparam logic [31:0] W_F      = 32'h0060_0313;
    localparam logic [31:0] W_BEQ    = 32'hFE00_0EE3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic        pred_taken_out;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_we         (imem_we),
        .imem_addr       (imem_addr),
        .imem_wdata      (imem_wdata),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .pred_taken_out  (pred_taken_out)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_pc_out;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_pred;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Program-flow view of the fetch: where does the instruction send the PC next.
    function automatic logic predict(input logic [31:0] w, input logic [31:0] pc,
                                     output logic [31:0] tgt);
        int off;
        tgt = pc + 32'd4;
        off = 0;
`ifdef IF_STATIC_PREDICT_EN
        if (w[6:0] == 7'b1100011 && w[31]) begin
            off = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            tgt = pc + 32'(off);
            return 1'b1;
        end
        if (w[6:0] == 7'b1101111) begin
            off = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            tgt = pc + 32'(off);
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic cycle();
        logic [31:0] fw;
        logic [31:0] tgt;
        logic        p;
        fw = mem[m_pc[9:2]];
        p  = predict(fw, m_pc, tgt);
        @(posedge clk);
        if (reset) begin
            m_pc = RST_PC; m_pc_out = 32'd0; m_instr = 32'h13; m_valid = 1'b0; m_pred = 1'b0;
        end else begin
            if (flush) begin
                m_pc_out = 32'd0; m_instr = 32'h13; m_valid = 1'b0; m_pred = 1'b0;
            end else if (!stall) begin
                m_pc_out = m_pc; m_instr = fw; m_valid = 1'b1; m_pred = p;
            end
            if (redirect_valid)  m_pc = redirect_pc;
            else if (!stall)     m_pc = tgt;
        end
        if (imem_we) mem[imem_addr] = imem_wdata;
        #1;
        check("model_pc",    PC_out,                 m_pc_out);
        check("model_instr", instruction_out,        m_instr);
        check("model_valid", {31'd0, valid_out},     {31'd0, m_valid});
        check("model_pred",  {31'd0, pred_taken_out}, {31'd0, m_pred});
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0:       w[6:0] = 7'b1100011;
            1:       w[6:0] = 7'b1101111;
            default: w[6:0] = 7'b0010011;
        endcase
        return w;
    endfunction

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_we = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        idle_inputs();
        imem_addr  = 8'd0;
        imem_wdata = 32'd0;
        m_pc = RST_PC; m_pc_out = 32'd0; m_instr = 32'h13; m_valid = 1'b0; m_pred = 1'b0;

        // Load the whole memory while held in reset.
        imem_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       w = W_A;
                1:       w = W_B;
                2:       w = W_C;
                3:       w = W_D;
                16:      w = W_E;
                255:     w = W_F;
                default: w = {$urandom_range(0, 32'h01FF_FFFF), 7'b0010011};
            endcase
            imem_addr  = 8'(i);
            imem_wdata = w;
            cycle();
        end
        imem_we = 1'b0;
        cycle();
        check("reset_pc",    PC_out,          32'd0);
        check("reset_instr", instruction_out, 32'h13);
        check("reset_valid", {31'd0, valid_out},      32'd0);
        check("reset_pred",  {31'd0, pred_taken_out}, 32'd0);

        // Sequential fetch after reset release.
        reset = 1'b0;
        cycle();
        check("seq0_pc", PC_out, 32'h0);  check("seq0_instr", instruction_out, W_A);
        check("seq0_valid", {31'd0, valid_out}, 32'd1);
        cycle();
        check("seq1_pc", PC_out, 32'h4);  check("seq1_instr", instruction_out, W_B);

        // Stall holds IF/ID and PC.
        stall = 1'b1;
        cycle();
        cycle();
        check("stall_pc", PC_out, 32'h4); check("stall_instr", instruction_out, W_B);
        stall = 1'b0;
        cycle();
        check("unstall_pc", PC_out, 32'h8); check("unstall_instr", instruction_out, W_C);

        // Flush wins over stall.
        flush = 1'b1; stall = 1'b1;
        cycle();
        check("flush_pc", PC_out, 32'h0); check("flush_instr", instruction_out, 32'h13);
        check("flush_valid", {31'd0, valid_out}, 32'd0);

        // Redirect under stall+flush.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        check("redir_bubble", {31'd0, valid_out}, 32'd0);
        idle_inputs();
        cycle();
        check("redir_pc", PC_out, 32'h40); check("redir_instr", instruction_out, W_E);
        check("redir_valid", {31'd0, valid_out}, 32'd1);

        // Address wrap past the top of memory.
        redirect_valid = 1'b1; redirect_pc = 32'h3FC; flush = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("top_pc", PC_out, 32'h3FC); check("top_instr", instruction_out, W_F);
        cycle();
        check("wrap_pc", PC_out, 32'h400); check("wrap_instr", instruction_out, W_A);

        // Backward branch at PC 8.
        imem_we = 1'b1; imem_addr = 8'd2; imem_wdata = W_BEQ;
        redirect_valid = 1'b1; redirect_pc = 32'h8; flush = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("beq_pc", PC_out, 32'h8); check("beq_instr", instruction_out, W_BEQ);
`ifdef IF_STATIC_PREDICT_EN
        check("beq_pred", {31'd0, pred_taken_out}, 32'd1);
        cycle();
        check("beq_next_pc", PC_out, 32'h4);
`else
        check("beq_pred", {31'd0, pred_taken_out}, 32'd0);
        cycle();
        check("beq_next_pc", PC_out, 32'hC);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 63) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            imem_we        = ($urandom_range(0, 3) == 0);
            imem_addr      = ($urandom_range(0, 1) == 0) ? m_pc[9:2] : 8'($urandom);
            imem_wdata     = rand_word();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
